// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
// NEG is only reachable when MULT_SIGNED_EN is defined.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // Counter has to hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder.sv
// WIDTH-bit ripple adder with carry in/out used by the multiplier accumulate step.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH shift-and-add multiplier, one partial product per cycle.
// Define MULT_SIGNED_EN to add the is_signed port and the NEG sign-fixup state.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
`ifdef MULT_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] mcand_in;
    logic [WIDTH-1:0] mplier_in;

    assign add_b = lo_q[0] ? mcand_q : '0;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a    (hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef MULT_SIGNED_EN
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   prod_neg;

    // Signed operands are reduced to magnitudes; the sign is reapplied in NEG.
    assign mcand_in  = (is_signed && mcand[WIDTH-1])  ? WIDTH'(0) - mcand  : mcand;
    assign mplier_in = (is_signed && mplier[WIDTH-1]) ? WIDTH'(0) - mplier : mplier;
    assign prod_neg  = (2*WIDTH)'(0) - {hi_q, lo_q};
`else
    assign mcand_in  = mcand;
    assign mplier_in = mplier;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    mcand_d = mcand_in;
                    hi_d    = '0;
                    lo_d    = mplier_in;
                    cnt_d   = CNT_W'(WIDTH);
`ifdef MULT_SIGNED_EN
                    neg_d   = is_signed && (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Carry out lands in the top bit; the consumed multiplier bit shifts out.
                {hi_d, lo_d} = {add_cout, add_sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef MULT_SIGNED_EN
                    state_d = NEG;
`else
                    state_d = DONE;
`endif
                end
            end
            NEG: begin
`ifdef MULT_SIGNED_EN
                if (neg_q) begin
                    {hi_d, lo_d} = prod_neg;
                end
                state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = (state_q == RUN) || (state_q == NEG);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=32).
// Signed cases are exercised only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    localparam int WIDTH = 32;
`ifdef MULT_SIGNED_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] mcand = '0;
    logic [WIDTH-1:0] mplier = '0;
`ifdef MULT_SIGNED_EN
    logic             is_signed = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int failures = 0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mcand     (mcand),
        .mplier    (mplier),
`ifdef MULT_SIGNED_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives start for exactly one rising edge; returns #1 after that edge.
    task automatic issue_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Counts edges until done is seen (starting from 'already'); busy must stay high before it.
    task automatic wait_done(input string tag, input int already, output int n);
        bit busy_ok = 1'b1;
        n = already;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int n;
        issue_start(a, b);
        check({tag, "_busy_start"}, busy, 1'b1);
        wait_done(tag, 0, n);
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        $display("op %s: %0h x %0h -> hi=%0h lo=%0h after %0d cycles", tag, a, b, hi, lo, n);
    endtask

    initial begin
        int  n;
        bit  saw_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
        run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("u0x9", 32'd0, 32'd9, 32'h0, 32'h0);

        // Hold: product stays visible in IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_busy", busy, 1'b0);
        check("idle_hold_done", done, 1'b0);
        check("idle_hold_lo", lo, 32'h0);

        // Start pulse mid-run with new operands must be ignored.
        issue_start(32'd3, 32'd5);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        mcand  = 32'd7;
        mplier = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("ignore_busy", busy, 1'b1);
        wait_done("ignore", 11, n);
        check("ignore_latency", 64'(n), 64'(LAT));
        check("ignore_lo", lo, 32'h0000000F);
        check("ignore_hi", hi, 32'h0);
        $display("op ignore: 3 x 5 with 7 x 7 pulse -> hi=%0h lo=%0h after %0d cycles", hi, lo, n);

        // Reset mid-run discards the operation.
        issue_start(32'd3, 32'd5);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        $display("op rst_mid: aborted, hi=%0h lo=%0h", hi, lo);
        run_op("u10000sq", 32'h00010000, 32'h00010000, 32'h00000001, 32'h0);

        // Back-to-back start in the DONE cycle.
        issue_start(32'd2, 32'd2);
        wait_done("b2b_first", 0, n);
        check("b2b_first_lo", lo, 32'd4);
        check("b2b_first_latency", 64'(n), 64'(LAT));
        mcand  = 32'd6;
        mplier = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("b2b_busy_next", busy, 1'b1);
        check("b2b_done_next", done, 1'b0);
        wait_done("b2b_second", 0, n);
        check("b2b_second_latency", 64'(n), 64'(LAT));
        check("b2b_second_hi", hi, 32'h0);
        check("b2b_second_lo", lo, 32'd42);
        $display("op b2b: 2 x 2 then 6 x 7 -> hi=%0h lo=%0h", hi, lo);

`ifdef MULT_SIGNED_EN
        is_signed = 1'b1;
        run_op("s_m3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("s_m3xm5", 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'h0000000F);
        is_signed = 1'b0;
        run_op("u_m3x5", 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
